// File: rtl/pipelined_alu_if.sv
// Issue/result bundle between the reservation station and the two-stage ALU.
// The op-code macros live here so every consumer of the bundle sees the same encoding.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif
`ifndef ALU_ADD
`define ALU_ADD  1
`define ALU_SUB  2
`define ALU_AND  3
`define ALU_OR   4
`define ALU_XOR  5
`define ALU_SHL  6
`define ALU_SHR  7
`define ALU_SHRA 8
`define ALU_EQ   9
`define ALU_NEQ  10
`define ALU_LT   11
`define ALU_LTU  12
`define ALU_GE   13
`define ALU_GEU  14
`endif

interface pipelined_alu_if #(
  parameter int XLEN           = 32,
  parameter int ALU_OP_WIDTH   = `ALU_OP_WIDTH,
  parameter int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH
);
  logic                      rs_ready;
  logic [ALU_OP_WIDTH-1:0]   rs_op;
  logic [XLEN-1:0]           rs_val1;
  logic [XLEN-1:0]           rs_val2;
  logic [ROB_SIZE_WIDTH-1:0] rs_id;
  logic                      alu_ready;
  logic [XLEN-1:0]           alu_res;
  logic [ROB_SIZE_WIDTH-1:0] alu_id;
  logic                      alu_busy;

  modport master (
    output rs_ready, rs_op, rs_val1, rs_val2, rs_id,
    input  alu_ready, alu_res, alu_id, alu_busy
  );

  modport slave (
    input  rs_ready, rs_op, rs_val1, rs_val2, rs_id,
    output alu_ready, alu_res, alu_id, alu_busy
  );
endinterface

// File: rtl/pipelined_alu.sv
// Two-stage integer ALU: result broadcast one edge after issue, one op per cycle.
// No back-pressure; rdy low freezes the whole pipe, flush kills both stages.
module pipelined_alu #(
  parameter int XLEN           = 32,
  parameter int ALU_OP_WIDTH   = `ALU_OP_WIDTH,
  parameter int ROB_SIZE_WIDTH = `ROB_SIZE_WIDTH
) (
  input logic            clk,
  input logic            rst,
  input logic            rdy,
  input logic            flush,
  pipelined_alu_if.slave io
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(`ALU_ADD);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(`ALU_SUB);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(`ALU_AND);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(`ALU_OR);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(`ALU_XOR);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHL  = ALU_OP_WIDTH'(`ALU_SHL);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHR  = ALU_OP_WIDTH'(`ALU_SHR);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHRA = ALU_OP_WIDTH'(`ALU_SHRA);
  localparam logic [ALU_OP_WIDTH-1:0] OP_EQ   = ALU_OP_WIDTH'(`ALU_EQ);
  localparam logic [ALU_OP_WIDTH-1:0] OP_NEQ  = ALU_OP_WIDTH'(`ALU_NEQ);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LT   = ALU_OP_WIDTH'(`ALU_LT);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LTU  = ALU_OP_WIDTH'(`ALU_LTU);
  localparam logic [ALU_OP_WIDTH-1:0] OP_GE   = ALU_OP_WIDTH'(`ALU_GE);
  localparam logic [ALU_OP_WIDTH-1:0] OP_GEU  = ALU_OP_WIDTH'(`ALU_GEU);

  logic [4:0]      shamt;
  logic [4:0]      coarse_amt;
  logic [XLEN-1:0] arith_d;
  logic [XLEN-1:0] shift_d;
  logic            cmp_d;

  assign shamt      = io.rs_val2[4:0];
  assign coarse_amt = {shamt[4:2], 2'b00};

  always_comb begin
    arith_d = '0;
    case (io.rs_op)
      OP_ADD:  arith_d = io.rs_val1 + io.rs_val2;
      OP_SUB:  arith_d = io.rs_val1 - io.rs_val2;
      OP_AND:  arith_d = io.rs_val1 & io.rs_val2;
      OP_OR:   arith_d = io.rs_val1 | io.rs_val2;
      OP_XOR:  arith_d = io.rs_val1 ^ io.rs_val2;
      default: arith_d = '0;
    endcase
  end

  always_comb begin
    cmp_d = 1'b0;
    case (io.rs_op)
      OP_EQ:   cmp_d = (io.rs_val1 == io.rs_val2);
      OP_NEQ:  cmp_d = (io.rs_val1 != io.rs_val2);
      OP_LT:   cmp_d = ($signed(io.rs_val1) <  $signed(io.rs_val2));
      OP_LTU:  cmp_d = (io.rs_val1 <  io.rs_val2);
      OP_GE:   cmp_d = ($signed(io.rs_val1) >= $signed(io.rs_val2));
      OP_GEU:  cmp_d = (io.rs_val1 >= io.rs_val2);
      default: cmp_d = 1'b0;
    endcase
  end

  // Shift is split across the stages: multiples of 4 here, the last 0..3 bits in S2.
  always_comb begin
    shift_d = io.rs_val1 >> coarse_amt;
    case (io.rs_op)
      OP_SHL:  shift_d = io.rs_val1 << coarse_amt;
      OP_SHRA: shift_d = $signed(io.rs_val1) >>> coarse_amt;
      default: shift_d = io.rs_val1 >> coarse_amt;
    endcase
  end

  logic                      v1;
  logic [ALU_OP_WIDTH-1:0]   op1;
  logic [ROB_SIZE_WIDTH-1:0] id1;
  logic [XLEN-1:0]           arith1;
  logic [XLEN-1:0]           shift1;
  logic                      cmp1;
  logic [1:0]                shlo1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1     <= 1'b0;
      op1    <= '0;
      id1    <= '0;
      arith1 <= '0;
      shift1 <= '0;
      cmp1   <= 1'b0;
      shlo1  <= '0;
    end else if (rdy) begin
      if (flush) begin
        v1 <= 1'b0;
      end else begin
        v1     <= io.rs_ready;
        op1    <= io.rs_op;
        id1    <= io.rs_id;
        arith1 <= arith_d;
        shift1 <= shift_d;
        cmp1   <= cmp_d;
        shlo1  <= shamt[1:0];
      end
    end
  end

  logic [XLEN-1:0] fine_shift;
  logic [XLEN-1:0] res_d;

  always_comb begin
    fine_shift = shift1 >> shlo1;
    case (op1)
      OP_SHL:  fine_shift = shift1 << shlo1;
      OP_SHRA: fine_shift = $signed(shift1) >>> shlo1;
      default: fine_shift = shift1 >> shlo1;
    endcase
  end

  always_comb begin
    res_d = '0;
    case (op1)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:         res_d = arith1;
      OP_SHL, OP_SHR, OP_SHRA:                       res_d = fine_shift;
      OP_EQ, OP_NEQ, OP_LT, OP_LTU, OP_GE, OP_GEU:   res_d = {{(XLEN-1){1'b0}}, cmp1};
      default:                                       res_d = '0;
    endcase
  end

  logic                      ready_q;
  logic [XLEN-1:0]           res_q;
  logic [ROB_SIZE_WIDTH-1:0] id_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q <= 1'b0;
      res_q   <= '0;
      id_q    <= '0;
    end else if (rdy) begin
      if (flush || !v1) begin
        ready_q <= 1'b0;
      end else begin
        ready_q <= 1'b1;
        res_q   <= res_d;
        id_q    <= id1;
      end
    end
  end

  assign io.alu_ready = ready_q;
  assign io.alu_res   = res_q;
  assign io.alu_id    = id_q;
  assign io.alu_busy  = v1 | ready_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu: hand-computed results, latency, flush, stall and reset.
module tb_pipelined_alu;

  localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4, XOR_ = 4'd5;
  localparam logic [3:0] SHL = 4'd6, SHR = 4'd7, SHRA = 4'd8;
  localparam logic [3:0] EQ = 4'd9, NEQ = 4'd10, LT = 4'd11, LTU = 4'd12, GE = 4'd13, GEU = 4'd14;

  logic clk;
  logic rst;
  logic rdy;
  logic flush;
  int   errors;
  int   checks;

  pipelined_alu_if #(.XLEN(32), .ALU_OP_WIDTH(4), .ROB_SIZE_WIDTH(4)) bus ();

  pipelined_alu #(.XLEN(32), .ALU_OP_WIDTH(4), .ROB_SIZE_WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .io    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id);
    bus.rs_ready = 1'b1;
    bus.rs_op    = op;
    bus.rs_val1  = a;
    bus.rs_val2  = b;
    bus.rs_id    = id;
  endtask

  task automatic idle();
    bus.rs_ready = 1'b0;
    bus.rs_op    = 4'd0;
    bus.rs_val1  = 32'h0;
    bus.rs_val2  = 32'h0;
    bus.rs_id    = 4'd0;
  endtask

  // Issues one op alone and checks its broadcast one edge later.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] id, input logic [31:0] exp);
    issue(op, a, b, id);
    tick();
    idle();
    tick();
    check({tag, "_ready"}, {31'd0, bus.alu_ready}, 32'd1);
    check({tag, "_res"}, bus.alu_res, exp);
    check({tag, "_id"}, {28'd0, bus.alu_id}, {28'd0, id});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    rdy    = 1'b1;
    flush  = 1'b0;
    idle();
    #1;
    check("reset_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("reset_res", bus.alu_res, 32'd0);
    check("reset_busy", {31'd0, bus.alu_busy}, 32'd0);
    #20;
    rst = 1'b1;
    tick();

    // back-to-back issue, results in order one edge after each issue
    issue(ADD, 32'h7FFF_FFFF, 32'h1, 4'd3);
    tick();
    check("b2b_busy", {31'd0, bus.alu_busy}, 32'd1);
    check("b2b_early", {31'd0, bus.alu_ready}, 32'd0);
    issue(SUB, 32'h0, 32'h1, 4'd4);
    tick();
    check("add_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("add_res", bus.alu_res, 32'h8000_0000);
    check("add_id", {28'd0, bus.alu_id}, 32'd3);
    issue(LTU, 32'h1, 32'hFFFF_FFFF, 4'd5);
    tick();
    check("sub_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("sub_res", bus.alu_res, 32'hFFFF_FFFF);
    check("sub_id", {28'd0, bus.alu_id}, 32'd4);
    idle();
    tick();
    check("ltu_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("ltu_res", bus.alu_res, 32'h0000_0001);
    check("ltu_id", {28'd0, bus.alu_id}, 32'd5);
    tick();
    check("one_shot_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("hold_res", bus.alu_res, 32'h0000_0001);
    check("idle_busy", {31'd0, bus.alu_busy}, 32'd0);

    // shifts
    run_op("shra31", SHRA, 32'h8000_0000, 32'd31, 4'd1, 32'hFFFF_FFFF);
    run_op("shr31", SHR, 32'h8000_0000, 32'd31, 4'd2, 32'h0000_0001);
    run_op("shl23", SHL, 32'h0000_0001, 32'h23, 4'd3, 32'h0000_0008);
    run_op("shl0", SHL, 32'h0000_ABCD, 32'd0, 4'd4, 32'h0000_ABCD);
    run_op("shra0", SHRA, 32'h8000_0001, 32'd0, 4'd5, 32'h8000_0001);
    run_op("shra5pos", SHRA, 32'h7000_0000, 32'd5, 4'd6, 32'h0380_0000);
    run_op("shl17", SHL, 32'h0000_0003, 32'd17, 4'd7, 32'h0006_0000);

    // logic ops
    run_op("and", AND_, 32'h0000_F0F0, 32'h0000_FF00, 4'd8, 32'h0000_F000);
    run_op("or", OR_, 32'h0000_F0F0, 32'h0000_FF00, 4'd9, 32'h0000_FFF0);
    run_op("xor", XOR_, 32'h0000_F0F0, 32'h0000_FF00, 4'd10, 32'h0000_0FF0);

    // branch compares
    run_op("ge_neg", GE, 32'hFFFF_FFFF, 32'h1, 4'd11, 32'd0);
    run_op("geu", GEU, 32'hFFFF_FFFF, 32'h1, 4'd12, 32'd1);
    run_op("neq", NEQ, 32'd5, 32'd5, 4'd13, 32'd0);
    run_op("eq", EQ, 32'd5, 32'd5, 4'd14, 32'd1);
    run_op("lt_neg", LT, 32'hFFFF_FFFF, 32'h1, 4'd15, 32'd1);

    // unknown op still broadcast with its tag
    run_op("unknown", 4'd0, 32'h1234_5678, 32'h1, 4'd6, 32'd0);
    run_op("op15", 4'd15, 32'h1234_5678, 32'h1, 4'd2, 32'd0);

    // flush at edge F kills ops sampled at F-1 and F
    issue(ADD, 32'd1, 32'd1, 4'd1);
    tick();
    issue(ADD, 32'd2, 32'd2, 4'd2);
    flush = 1'b1;
    tick();
    check("flush_f_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("flush_f_busy", {31'd0, bus.alu_busy}, 32'd0);
    flush = 1'b0;
    issue(ADD, 32'd10, 32'd20, 4'd7);
    tick();
    check("flush_f1_ready", {31'd0, bus.alu_ready}, 32'd0);
    idle();
    tick();
    check("flush_f2_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("flush_f2_res", bus.alu_res, 32'd30);
    check("flush_f2_id", {28'd0, bus.alu_id}, 32'd7);
    tick();
    check("flush_after", {31'd0, bus.alu_ready}, 32'd0);

    // rdy stall with op held in S1
    issue(ADD, 32'd2, 32'd3, 4'd9);
    tick();
    idle();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", {31'd0, bus.alu_ready}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    check("stall_out_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("stall_out_res", bus.alu_res, 32'd5);
    check("stall_out_id", {28'd0, bus.alu_id}, 32'd9);
    tick();
    check("stall_once", {31'd0, bus.alu_ready}, 32'd0);

    // rdy low while a result is on the bus keeps it there
    issue(SUB, 32'd100, 32'd1, 4'd8);
    tick();
    idle();
    tick();
    rdy = 1'b0;
    tick();
    tick();
    check("hold_ready", {31'd0, bus.alu_ready}, 32'd1);
    check("hold_res99", bus.alu_res, 32'd99);
    rdy = 1'b1;
    tick();
    check("hold_release", {31'd0, bus.alu_ready}, 32'd0);

    // asynchronous reset mid-stream with both stages full
    issue(ADD, 32'd40, 32'd2, 4'd11);
    tick();
    issue(ADD, 32'd1, 32'd1, 4'd12);
    tick();
    check("pre_rst_ready", {31'd0, bus.alu_ready}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("arst_res", bus.alu_res, 32'd0);
    check("arst_id", {28'd0, bus.alu_id}, 32'd0);
    check("arst_busy", {31'd0, bus.alu_busy}, 32'd0);
    idle();
    #10;
    rst = 1'b1;
    tick();
    tick();
    check("post_rst_ready", {31'd0, bus.alu_ready}, 32'd0);
    check("post_rst_busy", {31'd0, bus.alu_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
